// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the iterative MDU: launches one operation per M-extension instruction and returns one writeback beat.
// Latency: req at cycle 0, mdu_start at 1, mdu_done at D, mdu_ack at D+1, wb_valid at D+2 (a divide cache hit gives wb_valid at 1).
// Backpressure: stall holds execute for the whole operation; a flushed operation drains with stall low unless a new MDU op waits.
// Optional build macro MDU_FUSE_EN: one-entry divide result cache so a DIV/REM pair on the same operands skips the MDU.
module mdu_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic                 ex_is_mdu,
    input  logic [2:0]           ex_funct3,
    input  logic [XLEN-1:0]      ex_rs1_val,
    input  logic [XLEN-1:0]      ex_rs2_val,
    input  logic [REGW-1:0]      ex_rd,
    input  logic                 flush,
    output logic                 stall,
    output logic                 wb_valid,
    output logic [REGW-1:0]      wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic                 mdu_start,
    output logic                 mdu_ack,
    output logic [2:0]           mdu_funct3,
    output logic [XLEN-1:0]      mdu_a,
    output logic [XLEN-1:0]      mdu_b,
    input  logic                 mdu_busy,
    input  logic                 mdu_done,
    input  logic [2*XLEN-1:0]    mdu_product,
    input  logic [XLEN-1:0]      mdu_quotient,
    input  logic [XLEN-1:0]      mdu_remainder
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_kill;
    logic              r_start;
    logic              r_ack;
    logic              r_wb_valid;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_wb_data;
    logic [REGW-1:0]   r_wb_rd;

    logic              w_req;
    logic              w_stall;
    logic [XLEN-1:0]   w_result;
    logic              w_unused_busy;

    // Completion is tracked through done/ack only; busy is informational.
    assign w_unused_busy = mdu_busy;

    // A flush in the same cycle as the request cancels it before issue.
    assign w_req = ex_valid & ex_is_mdu & ~flush;

`ifdef MDU_FUSE_EN
    logic              r_c_vld;
    logic              r_c_sgn;
    logic [XLEN-1:0]   r_c_a;
    logic [XLEN-1:0]   r_c_b;
    logic [XLEN-1:0]   r_c_q;
    logic [XLEN-1:0]   r_c_r;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_data;

    // funct3[0] clear means signed divide/remainder; funct3[1] selects remainder.
    assign w_hit      = r_c_vld & ex_funct3[2] & (r_c_sgn == ~ex_funct3[0])
                      & (ex_rs1_val == r_c_a) & (ex_rs2_val == r_c_b);
    assign w_hit_data = ex_funct3[1] ? r_c_r : r_c_q;

    // Remember the last completed divide, killed or not, so its partner op can reuse it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c_vld <= 1'b0;
            r_c_sgn <= 1'b0;
            r_c_a   <= '0;
            r_c_b   <= '0;
            r_c_q   <= '0;
            r_c_r   <= '0;
        end else if (r_state == S_WAIT && mdu_done && r_funct3[2]) begin
            r_c_vld <= 1'b1;
            r_c_sgn <= ~r_funct3[0];
            r_c_a   <= r_a;
            r_c_b   <= r_b;
            r_c_q   <= mdu_quotient;
            r_c_r   <= mdu_remainder;
        end
    end
`endif

    // Pick the architectural result for the latched opcode; the MDU's values are taken as-is.
    always_comb begin
        w_result = mdu_remainder;
        case (r_funct3)
            3'b000:                 w_result = mdu_product[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = mdu_product[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_result = mdu_quotient;
            default:                w_result = mdu_remainder;
        endcase
    end

    // Hold execute while an op is live; once killed, only hold a new MDU op until the drain ends.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:                  w_stall = w_req;
            S_ISSUE, S_WAIT, S_ACK:  w_stall = r_kill ? (ex_valid & ex_is_mdu) : 1'b1;
            default:                 w_stall = 1'b0;
        endcase
    end

    // Handshake sequencer: issue, wait for done, ack once, then write back unless killed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_kill     <= 1'b0;
            r_start    <= 1'b0;
            r_ack      <= 1'b0;
            r_wb_valid <= 1'b0;
            r_funct3   <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
        end else begin
            r_start    <= 1'b0;
            r_ack      <= 1'b0;
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_funct3 <= ex_funct3;
                        r_a      <= ex_rs1_val;
                        r_b      <= ex_rs2_val;
                        r_wb_rd  <= ex_rd;
                        r_kill   <= 1'b0;
`ifdef MDU_FUSE_EN
                        if (w_hit) begin
                            r_wb_data  <= w_hit_data;
                            r_wb_valid <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end
`else
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (mdu_done) begin
                        r_wb_data <= w_result;
                        r_ack     <= 1'b1;
                        r_state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    // A flush arriving in this very cycle still suppresses writeback.
                    if (r_kill || flush) begin
                        r_kill  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_wb_valid <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall      = w_stall;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign mdu_start  = r_start;
    assign mdu_ack    = r_ack;
    assign mdu_funct3 = r_funct3;
    assign mdu_a      = r_a;
    assign mdu_b      = r_b;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: behavioural MDU with random latency plus an ISA-level result and cache model.
// Latency: checked per instruction against the done/ack/writeback cycle relationship.
// Backpressure: the bench acts as the execute stage and holds each instruction while stall is high.
module tb_mdu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_is_mdu, flush;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1_val, ex_rs2_val;
    logic [4:0]  ex_rd;
    logic        stall, wb_valid, mdu_start, mdu_ack;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, mdu_a, mdu_b;
    logic [2:0]  mdu_funct3;
    logic        mdu_busy, mdu_done;
    logic [63:0] mdu_product;
    logic [31:0] mdu_quotient, mdu_remainder;

    int n_chk = 0;
    int n_err = 0;
    int mdu_lat = 3;
    int proto_err = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_mdu(ex_is_mdu), .ex_funct3(ex_funct3),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd),
        .flush(flush), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_start(mdu_start), .mdu_ack(mdu_ack), .mdu_funct3(mdu_funct3),
        .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
        .mdu_product(mdu_product), .mdu_quotient(mdu_quotient), .mdu_remainder(mdu_remainder)
    );

    // ---------------- ISA-level arithmetic ----------------
    function automatic logic [63:0] prod64(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3[1:0])
            2'b01:   return sa * sb;
            2'b10:   return sa * $signed(ub);
            default: return ua * ub;
        endcase
    endfunction

    function automatic logic [31:0] divrem(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q, r;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return f3[1] ? r : q;
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (f3[2]) return divrem(f3, a, b);
        p = prod64(f3, a, b);
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    // ---------------- behavioural MDU ----------------
    logic        m_busy, m_done;
    int          m_cnt;
    logic [2:0]  m_f3;
    logic [31:0] m_a, m_b;
    logic [63:0] m_junk;

    always @(posedge clk) begin
        m_junk <= {$urandom, $urandom};
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            if (mdu_start) begin
                if (m_busy || m_done) proto_err <= proto_err + 1;
                m_busy <= 1'b1;
                m_cnt  <= mdu_lat;
                m_f3   <= mdu_funct3;
                m_a    <= mdu_a;
                m_b    <= mdu_b;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (mdu_ack) begin
                if (!m_done) proto_err <= proto_err + 1;
                m_done <= 1'b0;
            end
        end
    end

    assign mdu_busy      = m_busy;
    assign mdu_done      = m_done;
    assign mdu_product   = m_done ? prod64(m_f3, m_a, m_b) : m_junk;
    assign mdu_quotient  = m_done ? divrem({2'b10, m_f3[0]}, m_a, m_b) : m_junk[31:0];
    assign mdu_remainder = m_done ? divrem({2'b11, m_f3[0]}, m_a, m_b) : m_junk[63:32];

    // ---------------- divide cache model ----------------
    bit          c_vld = 1'b0;
    bit          c_sgn;
    logic [31:0] c_a, c_b;

    function automatic bit exp_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_FUSE_EN
        return f3[2] && c_vld && (c_sgn == !f3[0]) && (a == c_a) && (b == c_b);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cache_fill(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            c_vld = 1'b1;
            c_sgn = !f3[0];
            c_a   = a;
            c_b   = b;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ex_valid   = 1'b1;
        ex_is_mdu  = 1'b1;
        ex_funct3  = f3;
        ex_rs1_val = a;
        ex_rs2_val = b;
        ex_rd      = rd;
    endtask

    // Present one instruction, hold it while stalled, and check timing and result.
    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int n_st = 0, n_ak = 0, n_wb = 0, st_c = -1, dn_c = -1, ak_c = -1, wb_c = -1, bad = 0, c = 0;
        bit fin = 1'b0;
        bit hit;
        logic [31:0] d = 32'd0, exp;
        logic [4:0]  r = 5'd0;
        hit = exp_hit(f3, a, b);
        exp = ref_result(f3, a, b);
        @(posedge clk); #1;
        drive_op(f3, a, b, rd);
        while (!fin && c < 300) begin
            @(negedge clk);
            if (mdu_start) begin n_st++; st_c = c; end
            if (mdu_done && dn_c < 0) dn_c = c;
            if (mdu_ack) begin n_ak++; ak_c = c; end
            if (wb_valid) begin n_wb++; wb_c = c; d = wb_data; r = wb_rd; end
            if (stall === wb_valid) bad++;
            if (!stall) fin = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        ex_valid  = 1'b0;
        ex_is_mdu = 1'($urandom);
        if (!fin) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_wb_cnt"}, n_wb, 1);
        chk({nm, "_wb_data"}, d, exp);
        chk({nm, "_wb_rd"}, r, rd);
        chk({nm, "_stall"}, bad, 0);
        if (hit) begin
            chk({nm, "_hit_starts"}, n_st, 0);
            chk({nm, "_hit_acks"}, n_ak, 0);
            chk({nm, "_hit_lat"}, wb_c, 1);
        end else begin
            chk({nm, "_starts"}, n_st, 1);
            chk({nm, "_start_cyc"}, st_c, 1);
            chk({nm, "_acks"}, n_ak, 1);
            chk({nm, "_ack_lat"}, ak_c - dn_c, 1);
            chk({nm, "_wb_lat"}, wb_c - dn_c, 2);
            cache_fill(f3, a, b);
        end
    endtask

    // DIVU 1000/7 flushed in its second WAIT cycle, followed by MUL 3*5 waiting for the drain.
    task automatic do_flush_seq();
        int n_st = 0, n_ak = 0, n_wb = 0, ak1_c = -1, st2_c = -1, bad = 0, c = 0;
        bit fin = 1'b0;
        logic stall_c4 = 1'b1;
        logic [31:0] d = 32'd0;
        logic [4:0]  r = 5'd0;
        mdu_lat = 8;
        @(posedge clk); #1;
        drive_op(3'b101, 32'd1000, 32'd7, 5'd9);
        while (!fin && c < 300) begin
            @(negedge clk);
            if (mdu_start) begin n_st++; if (n_st == 2) st2_c = c; end
            if (mdu_ack) begin n_ak++; if (n_ak == 1) ak1_c = c; end
            if (wb_valid) begin n_wb++; d = wb_data; r = wb_rd; end
            if (c == 4) stall_c4 = stall;
            else if (stall === wb_valid) bad++;
            if (c >= 5 && !stall) fin = 1'b1;
            @(posedge clk); #1;
            if (c == 2) flush = 1'b1;
            if (c == 3) begin flush = 1'b0; ex_valid = 1'b0; end
            if (c == 4) drive_op(3'b000, 32'd3, 32'd5, 5'd10);
            c++;
        end
        ex_valid = 1'b0;
        if (!fin) chk("flush_timeout", 0, 1);
        chk("flush_stall_drop", stall_c4, 0);
        chk("flush_stall", bad, 0);
        chk("flush_starts", n_st, 2);
        chk("flush_acks", n_ak, 2);
        chk("flush_wb_cnt", n_wb, 1);
        chk("flush_mul_data", d, 32'd15);
        chk("flush_mul_rd", r, 5'd10);
        chk("flush_drain_order", st2_c > ak1_c, 1);
        cache_fill(3'b101, 32'd1000, 32'd7);
    endtask

    // Reset in the middle of a long MUL, then a fresh MUL 2*2.
    task automatic do_reset_seq();
        int stray = 0;
        mdu_lat = 20;
        @(posedge clk); #1;
        drive_op(3'b000, 32'd9, 32'd9, 5'd5);
        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        c_vld = 1'b0;
        @(negedge clk);
        chk("rst_mid_start", mdu_start, 0);
        chk("rst_mid_ack", mdu_ack, 0);
        chk("rst_mid_wb_valid", wb_valid, 0);
        chk("rst_mid_wb_data", wb_data, 0);
        chk("rst_mid_wb_rd", wb_rd, 0);
        chk("rst_mid_ops", {mdu_funct3, mdu_a, mdu_b}, 0);
        chk("rst_mid_stall", stall, 0);
        repeat (25) begin
            @(negedge clk);
            if (mdu_start || mdu_ack || wb_valid) stray++;
        end
        chk("rst_mid_quiet", stray, 0);
        mdu_lat = 2;
        do_op("mul2x2", 3'b000, 32'd2, 32'd2, 5'd6);
    endtask

    logic [31:0] pool [8];

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ex_valid = 1'b0;
        ex_is_mdu = 1'b0;
        ex_funct3 = 3'd0;
        ex_rs1_val = 32'd0;
        ex_rs2_val = 32'd0;
        ex_rd = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start", mdu_start, 0);
        chk("rst_ack", mdu_ack, 0);
        chk("rst_wb", {wb_valid, wb_rd, wb_data}, 0);
        chk("rst_ops", {mdu_funct3, mdu_a, mdu_b}, 0);
        chk("rst_stall", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        mdu_lat = 3;
        do_op("mul7x6", 3'b000, 32'd7, 32'd6, 5'd3);
        do_op("mulh_m1x2", 3'b001, 32'hFFFF_FFFF, 32'd2, 5'd4);
        do_op("mul_m1x2", 3'b000, 32'hFFFF_FFFF, 32'd2, 5'd5);
        do_op("divu_by0", 3'b101, 32'd100, 32'd0, 5'd7);
        do_op("remu_by0", 3'b111, 32'd100, 32'd0, 5'd8);
        do_flush_seq();
        mdu_lat = 4;
        do_op("divu_after_kill", 3'b101, 32'd1000, 32'd7, 5'd11);
        do_op("div_m20_3", 3'b100, 32'hFFFF_FFEC, 32'd3, 5'd12);
        do_op("rem_m20_3", 3'b110, 32'hFFFF_FFEC, 32'd3, 5'd13);

        // Request killed in the same cycle it is presented: no issue.
        @(posedge clk); #1;
        drive_op(3'b000, 32'd5, 32'd5, 5'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_same_cycle_stall", stall, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("flush_same_cycle_start", mdu_start, 0);

        pool = '{32'd0, 32'd1, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFEC, 32'd3, 32'd0};
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            mdu_lat = $urandom_range(1, 6);
            f3 = 3'($urandom_range(0, 7));
            pool[7] = $urandom;
            if (c_vld && $urandom_range(0, 2) == 0) begin
                a = c_a;
                b = c_b;
            end else begin
                a = pool[$urandom_range(0, 7)];
                b = pool[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                ex_valid  = 1'b1;
                ex_is_mdu = 1'b0;
                @(negedge clk);
                chk("nonmdu_stall", {stall, mdu_start}, 0);
                @(posedge clk); #1;
                ex_valid = 1'b0;
            end
            do_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, 5'($urandom));
        end

        do_reset_seq();

        chk("mdu_protocol", proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Pipeline-side controller for the iterative multiply/divide unit. It implements the initiator end of the MDU start/busy/done/ack handshake.
- Accepts a decoded M-extension instruction from the execute stage and launches exactly one MDU operation per instruction.
- Stalls the pipeline while the operation runs, selects the architectural result, and presents one writeback beat.
- Handles flushes and drains a killed operation safely.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- REGW, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute-stage instruction valid
- ex_is_mdu  in  1  instruction is MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
- ex_funct3  in  3  M-extension funct3
- ex_rs1_val  in  32  operand a
- ex_rs2_val  in  32  operand b
- ex_rd  in  5  destination register
- flush  in  1  kill current execute instruction
- stall  out  1  hold execute stage
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- mdu_start  out  1  one-cycle start pulse
- mdu_ack  out  1  one-cycle completion acknowledge
- mdu_funct3  out  3  latched funct3
- mdu_a  out  32  latched operand a
- mdu_b  out  32  latched operand b
- mdu_busy  in  1  MDU busy
- mdu_done  in  1  MDU done; held high until acked
- mdu_product  in  64  MDU product
- mdu_quotient  in  32  MDU quotient
- mdu_remainder  in  32  MDU remainder

Behaviour:
- Reset values: all registered outputs are 0 (mdu_start, mdu_ack, mdu_funct3, mdu_a, mdu_b, wb_valid, wb_rd, wb_data). state=IDLE, kill=0.
- Define req = ex_valid & ex_is_mdu & !flush.
- States are IDLE, ISSUE, WAIT, ACK, DONE.
- IDLE:
  - On req, latch funct3, a, b, rd; kill<=0; go to ISSUE.
  - stall = req (combinational).
- ISSUE:
  - mdu_start=1 for this cycle only, with the latched operands stable.
  - Next state is WAIT.
  - stall=1 unless kill.
- WAIT:
  - mdu_done is sampled only in this state.
  - On mdu_done, capture the selected result into wb_data, register mdu_ack=1, go to ACK.
  - stall=1 unless kill.
- ACK:
  - mdu_ack=1 for exactly one cycle.
  - If !kill, go to DONE; else go to IDLE.
  - stall=1 unless kill.
- DONE:
  - wb_valid=1 and stall=0; the pipeline advances at the end of this cycle.
  - Next state is IDLE.
  - No new request is accepted in DONE.
- Result select:
  - 000 (MUL) -> product[31:0]
  - 001/010/011 (MULH/MULHSU/MULHU) -> product[63:32]
  - 100/101 (DIV/DIVU) -> quotient
  - 110/111 (REM/REMU) -> remainder
- The controller performs no arithmetic correction; the MDU alone defines div-by-zero and overflow results.
- Latency: req at cycle 0 -> start at cycle 1 -> done at cycle D -> ack at D+1 -> wb_valid at D+2.
- Flush in ISSUE, WAIT or ACK:
  - Set kill. The operation still runs to done and ack pulses exactly once.
  - wb_valid is suppressed and stall drops to 0.
  - While kill is set and state != IDLE, stall = ex_valid & ex_is_mdu; a new MDU instruction waits for the drain.
- A flush in the same cycle as req in IDLE means no issue.
- Reset mid-operation returns the controller to IDLE with no ack. The MDU is reset by the same rst_n.
- mdu_start is never asserted while state != ISSUE. At most one operation is outstanding.

Optional Feature:
- Macro: MDU_FUSE_EN.
- When defined:
  - Keep a one-entry cache {valid, signed = !funct3[0], a, b, quotient, remainder}.
  - The cache is filled on every completed divide-class operation, including killed ones.
  - In IDLE, a divide-class req that hits (valid, same signedness, a==cached a, b==cached b) goes directly to DONE with the cached quotient or remainder; there is no mdu_start and no ack. stall=1 in the IDLE cycle.
  - The cache is invalidated on reset.
- When undefined: every request goes through the MDU.

Test Plan:
- MUL a=7 b=6 -> single mdu_start pulse; stall high from req through ACK; wb_valid one cycle with wb_data=42, wb_rd=ex_rd; single mdu_ack.
- MULH a=0xFFFFFFFF b=2 -> product 0xFFFFFFFFFFFFFFFE; wb_data=0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFFE.
- DIVU a=100 b=0 -> wb_data=0xFFFFFFFF; REMU a=100 b=0 -> wb_data=100.
- DIVU 1000/7 with flush two cycles into WAIT -> stall drops, no wb_valid, mdu_ack pulses once. A following MUL 3*5 stalls until IDLE, then wb_data=15.
- DIV -20/3 then REM -20/3 -> 0xFFFFFFFA then 0xFFFFFFFE.
  - With MDU_FUSE_EN: the second has no mdu_start and wb_valid one cycle after req.
  - Without it: two starts.
- rst_n low during WAIT -> next cycle all outputs 0, state IDLE. A fresh MUL 2*2 -> wb_data=4.
